// File: rtl/elevator_controller_pkg.sv
// Shared types for the elevator controller: FSM states and direction encoding.
package elevator_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVING    = 2'd1,
        DOOR_OPEN = 2'd2
    } state_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/elevator_controller_if.sv
// Request-mask / car-status bundle between request_handler and elevator_controller.
// ELEVATOR_ESTOP_EN adds the emergency_stop input to the bundle.
interface elevator_if #(
  parameter int NUM_FLOORS  = 10,
  parameter int FLOOR_WIDTH = 4
);
  logic [NUM_FLOORS-1:0]  floor_requests;
  logic [FLOOR_WIDTH-1:0] current_floor;
  logic                   clear_current_request;
  logic                   direction;
  logic                   moving;
  logic                   door_open;
`ifdef ELEVATOR_ESTOP_EN
  logic                   emergency_stop;
`endif

  // master is the car controller, slave is the request side feeding it
  modport master (
    input  floor_requests,
`ifdef ELEVATOR_ESTOP_EN
    input  emergency_stop,
`endif
    output current_floor, clear_current_request, direction, moving, door_open
  );

  modport slave (
    output floor_requests,
`ifdef ELEVATOR_ESTOP_EN
    output emergency_stop,
`endif
    input  current_floor, clear_current_request, direction, moving, door_open
  );
endinterface

// File: rtl/elevator_controller_scan.sv
// Combinational split of the request mask around the car: request here, any above, any below.
module floor_request_scan #(
  parameter int NUM_FLOORS  = 10,
  parameter int FLOOR_WIDTH = 4
) (
  input  logic [NUM_FLOORS-1:0]  floor_requests,
  input  logic [FLOOR_WIDTH-1:0] current_floor,
  output logic                   here,
  output logic                   above,
  output logic                   below
);
  always_comb begin
    here  = 1'b0;
    above = 1'b0;
    below = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (i == int'(current_floor))
        here = floor_requests[i];
      else if (i > int'(current_floor))
        above = above | floor_requests[i];
      else
        below = below | floor_requests[i];
    end
  end
endmodule

// File: rtl/elevator_controller.sv
// SCAN car controller: steps one floor per TRAVEL_CYCLES, holds the door for DOOR_CYCLES.
// ELEVATOR_ESTOP_EN adds emergency_stop, which freezes whichever counter is running.
module elevator_controller
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS    = 10,
  parameter int FLOOR_WIDTH   = 4,
  parameter int TRAVEL_CYCLES = 8,
  parameter int DOOR_CYCLES   = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  elevator_if.master bus
);
  localparam int TW = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
  localparam int DW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [TW-1:0] TRAVEL_LAST = TW'(TRAVEL_CYCLES - 1);
  localparam logic [DW-1:0] DOOR_LAST   = DW'(DOOR_CYCLES - 1);

  state_t                 state;
  logic [FLOOR_WIDTH-1:0] floor_q;
  logic [TW-1:0]          travel_cnt;
  logic [DW-1:0]          door_cnt;
  logic                   dir_q, moving_q, door_q, clear_q;
  logic                   here, above, below, ahead, behind;
  logic                   hold;

`ifdef ELEVATOR_ESTOP_EN
  assign hold = bus.emergency_stop;
`else
  assign hold = 1'b0;
`endif

  floor_request_scan #(
    .NUM_FLOORS  (NUM_FLOORS),
    .FLOOR_WIDTH (FLOOR_WIDTH)
  ) u_scan (
    .floor_requests (bus.floor_requests),
    .current_floor  (floor_q),
    .here           (here),
    .above          (above),
    .below          (below)
  );

  assign ahead  = (dir_q == DIR_UP) ? above : below;
  assign behind = (dir_q == DIR_UP) ? below : above;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      floor_q    <= '0;
      dir_q      <= DIR_UP;
      travel_cnt <= '0;
      door_cnt   <= '0;
      moving_q   <= 1'b0;
      door_q     <= 1'b0;
      clear_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!hold) begin
            if (here) begin
              state   <= DOOR_OPEN;
              door_q  <= 1'b1;
              clear_q <= 1'b1;
            end else if (ahead) begin
              state    <= MOVING;
              moving_q <= 1'b1;
            end else if (behind) begin
              // reversal is the only place the direction preference changes
              dir_q    <= ~dir_q;
              state    <= MOVING;
              moving_q <= 1'b1;
            end
          end
        end
        MOVING: begin
          if (hold) begin
            moving_q <= 1'b0;
          end else if (travel_cnt == TRAVEL_LAST) begin
            travel_cnt <= '0;
            floor_q    <= (dir_q == DIR_UP) ? floor_q + FLOOR_WIDTH'(1)
                                            : floor_q - FLOOR_WIDTH'(1);
            state      <= IDLE;
            moving_q   <= 1'b0;
          end else begin
            travel_cnt <= travel_cnt + TW'(1);
            moving_q   <= 1'b1;
          end
        end
        DOOR_OPEN: begin
          if (!hold) begin
            if (door_cnt == DOOR_LAST) begin
              door_cnt <= '0;
              state    <= IDLE;
              door_q   <= 1'b0;
              clear_q  <= 1'b0;
            end else begin
              door_cnt <= door_cnt + DW'(1);
            end
          end
        end
        default: begin
          state    <= IDLE;
          moving_q <= 1'b0;
          door_q   <= 1'b0;
          clear_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.current_floor         = floor_q;
  assign bus.direction             = dir_q;
  assign bus.moving                = moving_q;
  assign bus.door_open             = door_q;
  assign bus.clear_current_request = clear_q;
endmodule
